// File: rtl/vdp_sprite_line_buffer_if.sv
// Renderer write bus and scanout read bus of the sprite line buffer.
//   master : renderer/compositor side (drives writes and read requests, receives pixels)
//   slave  : line buffer side
interface vdp_sprite_line_buffer_if #(
    parameter int unsigned ADDR_BITS = 10
);
    localparam int unsigned DATA_BITS = 10;

    logic                 render_write_en;
    logic [ADDR_BITS-1:0] render_write_address;
    logic [DATA_BITS-1:0] render_write_data;
    logic [ADDR_BITS-1:0] raster_x;
    logic                 raster_x_valid;
    logic                 pixel_valid;
    logic [DATA_BITS-1:0] pixel_data;
    logic                 pixel_opaque;

    modport master (
        output render_write_en, render_write_address, render_write_data,
        output raster_x, raster_x_valid,
        input  pixel_valid, pixel_data, pixel_opaque
    );

    modport slave (
        input  render_write_en, render_write_address, render_write_data,
        input  raster_x, raster_x_valid,
        output pixel_valid, pixel_data, pixel_opaque
    );
endinterface

// File: rtl/vdp_sprite_line_buffer.sv
// Double-buffered sprite line buffer with clear-on-read scanout.
//   clk, reset_n : clock, async active-low reset
//   line_start   : scanline start pulse, swaps front/back banks
//   ready        : high once both banks have been swept to zero
//   bus          : renderer writes (back bank) and scanout reads (front bank),
//                  2-cycle read latency, {priority, palette, pixel} data
module vdp_sprite_line_buffer #(
    parameter int unsigned LINE_WIDTH = 848,
    parameter int unsigned ADDR_BITS  = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic line_start,
    output logic ready,
    vdp_sprite_line_buffer_if.slave bus
);
    localparam int unsigned DATA_BITS = 10;
    localparam int unsigned DEPTH     = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] LINE_LIMIT = (ADDR_BITS+1)'(LINE_WIDTH);

    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t               state;
    state_t               state_next;
    logic [ADDR_BITS-1:0] init_cnt;
    logic                 front;

    logic run;
    logic render_ok;
    logic read_req;
    logic swap;

    logic                 s1_valid;
    logic [ADDR_BITS-1:0] s1_addr;
    logic                 s1_tag;
    logic [ADDR_BITS-1:0] s2_addr;
    logic                 s2_tag;
    logic                 fwd;

    logic [1:0]           we;
    logic [ADDR_BITS-1:0] wa [2];
    logic [DATA_BITS-1:0] wd [2];
    logic [DATA_BITS-1:0] rd0;
    logic [DATA_BITS-1:0] rd1;
    logic [DATA_BITS-1:0] bank0 [DEPTH];
    logic [DATA_BITS-1:0] bank1 [DEPTH];

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_INIT;
        else          state <= state_next;
    end

    // Next state: leave INIT after the last address has been cleared
    always_comb begin
        state_next = state;
        if (state == ST_INIT && init_cnt == '1) state_next = ST_RUN;
    end

    // Decoded controls: everything from the outside world is ignored in INIT
    always_comb begin
        run       = (state == ST_RUN);
        render_ok = run && bus.render_write_en
                    && ({1'b0, bus.render_write_address} < LINE_LIMIT);
        read_req  = run && bus.raster_x_valid;
        swap      = run && line_start;
    end

    // Per-bank write port: init sweep, else render to back, else scanout clear.
    // A stale clear landing on the new back bank loses to a render write.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            we[b] = 1'b0;
            wa[b] = s1_addr;
            wd[b] = '0;
            if (!run) begin
                we[b] = 1'b1;
                wa[b] = init_cnt;
            end else if (render_ok && (front != 1'(b))) begin
                we[b] = 1'b1;
                wa[b] = bus.render_write_address;
                wd[b] = bus.render_write_data;
            end else if (s1_valid && (s1_tag == 1'(b))) begin
                we[b] = 1'b1;
            end
        end
    end

    // Bank RAMs, read-before-write
    always_ff @(posedge clk) begin
        if (we[0]) bank0[wa[0]] <= wd[0];
        rd0 <= bank0[bus.raster_x];
    end

    always_ff @(posedge clk) begin
        if (we[1]) bank1[wa[1]] <= wd[1];
        rd1 <= bank1[bus.raster_x];
    end

    // The RAM read in stage 1 cannot see the clear issued by the previous
    // request in the same cycle, so a back-to-back repeat is forced to zero.
    assign fwd = bus.pixel_valid && (s2_addr == s1_addr) && (s2_tag == s1_tag);

    // Init counter, bank select and scanout pipeline
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_cnt        <= '0;
            front           <= 1'b0;
            ready           <= 1'b0;
            s1_valid        <= 1'b0;
            s1_addr         <= '0;
            s1_tag          <= 1'b0;
            s2_addr         <= '0;
            s2_tag          <= 1'b0;
            bus.pixel_valid <= 1'b0;
            bus.pixel_data  <= '0;
        end else begin
            if (!run) init_cnt <= init_cnt + ADDR_BITS'(1);
            if (swap) front <= ~front;
            ready           <= (state_next == ST_RUN);
            s1_valid        <= read_req;
            s1_addr         <= bus.raster_x;
            s1_tag          <= front;
            s2_addr         <= s1_addr;
            s2_tag          <= s1_tag;
            bus.pixel_valid <= s1_valid;
            bus.pixel_data  <= (s1_valid && !fwd) ? (s1_tag ? rd1 : rd0) : '0;
        end
    end

    assign bus.pixel_opaque = bus.pixel_valid && (bus.pixel_data[3:0] != 4'd0);

endmodule

// File: tb/tb_vdp_sprite_line_buffer.sv
// Randomized bench for vdp_sprite_line_buffer against a two-bank array model.
module tb_vdp_sprite_line_buffer;
    localparam int unsigned LW    = 848;
    localparam int unsigned DEPTH = 1024;

    logic clk = 1'b0;
    logic reset_n;
    logic line_start;
    logic ready;

    vdp_sprite_line_buffer_if #(.ADDR_BITS(10)) bus ();

    vdp_sprite_line_buffer #(.LINE_WIDTH(LW), .ADDR_BITS(10)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .line_start (line_start),
        .ready      (ready),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: two banks, front index, cycles left in the init sweep,
    // and the two in-flight expected pixels.
    logic [9:0] mem_m [2][DEPTH];
    int         front_m;
    int         init_left;
    logic       pv_q [2];
    logic [9:0] pd_q [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check outputs for the request of two cycles ago,
    // then apply new inputs and advance the model.
    task automatic step(input logic en, input logic [9:0] wa, input logic [9:0] wd,
                        input logic rv, input logic [9:0] rx, input logic ls);
        logic run;
        @(negedge clk);
        if (init_left > 0) init_left--;
        run = (init_left == 0);
        check_eq("ready", 32'(ready), 32'(run));
        check_eq("pixel_valid", 32'(bus.pixel_valid), 32'(pv_q[1]));
        if (pv_q[1]) check_eq("pixel_data", 32'(bus.pixel_data), 32'(pd_q[1]));
        check_eq("pixel_opaque", 32'(bus.pixel_opaque),
                 32'(pv_q[1] && (pd_q[1][3:0] != 4'd0)));
        pv_q[1] = pv_q[0];
        pd_q[1] = pd_q[0];

        bus.render_write_en      = en;
        bus.render_write_address = wa;
        bus.render_write_data    = wd;
        bus.raster_x_valid       = rv;
        bus.raster_x             = rx;
        line_start               = ls;

        pv_q[0] = run && rv;
        pd_q[0] = '0;
        if (run) begin
            if (rv) begin
                pd_q[0] = mem_m[front_m][rx];
                mem_m[front_m][rx] = '0;
            end
            if (en && int'(wa) < LW) mem_m[1-front_m][wa] = wd;
            if (ls) front_m = 1 - front_m;
        end
    endtask

    task automatic idle();
        step(1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 1'b0);
    endtask

    task automatic rand_step(input logic allow_read, input logic ls);
        logic [9:0] wa;
        logic [9:0] rx;
        wa = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 31));
        rx = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 31));
        step(1'($urandom_range(0, 1)), wa, 10'($urandom),
             allow_read && ($urandom_range(0, 9) < 7), rx, ls);
    endtask

    task automatic do_reset();
        bus.render_write_en      = 1'b0;
        bus.render_write_address = '0;
        bus.render_write_data    = '0;
        bus.raster_x_valid       = 1'b0;
        bus.raster_x             = '0;
        line_start               = 1'b0;
        reset_n                  = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < int'(DEPTH); a++) mem_m[b][a] = '0;
        front_m   = 0;
        init_left = 1024;
        pv_q[0] = 1'b0; pv_q[1] = 1'b0;
        pd_q[0] = '0;   pd_q[1] = '0;
    endtask

    // Init sweep with random traffic that must be ignored
    task automatic run_init();
        repeat (1023) rand_step(1'b1, 1'($urandom_range(0, 1)));
    endtask

    // A full line reading every address of the front bank
    task automatic read_all();
        step(1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 1'b1);
        for (int x = 0; x < int'(DEPTH); x++) step(1'b0, 10'd0, 10'd0, 1'b1, 10'(x), 1'b0);
        idle();
    endtask

    initial begin
        reset_n = 1'b0;
        do_reset();
        check_eq("ready_after_release", 32'(ready), 32'd0);
        run_init();
        read_all();
        read_all();

        // Writes to back bank, including out-of-range ones
        step(1'b1, 10'd100,  10'h3A5, 1'b0, 10'd0, 1'b0);
        step(1'b1, 10'd848,  10'h3FF, 1'b0, 10'd0, 1'b0);
        step(1'b1, 10'd1023, 10'h155, 1'b0, 10'd0, 1'b0);
        step(1'b1, 10'd5,    10'h2B7, 1'b0, 10'd0, 1'b0);
        idle();
        step(1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 1'b1);
        idle();
        step(1'b0, 10'd0,   10'd0,   1'b1, 10'd100,  1'b0);
        step(1'b0, 10'd0,   10'd0,   1'b1, 10'd100,  1'b0);
        step(1'b0, 10'd0,   10'd0,   1'b1, 10'd101,  1'b0);
        step(1'b0, 10'd0,   10'd0,   1'b1, 10'd0,    1'b0);
        step(1'b0, 10'd0,   10'd0,   1'b1, 10'd848,  1'b0);
        step(1'b0, 10'd0,   10'd0,   1'b1, 10'd1023, 1'b0);
        step(1'b0, 10'd0,   10'd0,   1'b1, 10'd208,  1'b0);
        // Write back x=5 while reading front x=5
        step(1'b1, 10'd5,   10'h0C3, 1'b1, 10'd5,    1'b0);
        idle();
        idle();
        step(1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 1'b1);
        step(1'b0, 10'd0, 10'd0, 1'b1, 10'd5, 1'b0);
        idle();
        step(1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 1'b1);
        step(1'b0, 10'd0, 10'd0, 1'b1, 10'd100, 1'b0);
        step(1'b0, 10'd0, 10'd0, 1'b1, 10'd5, 1'b0);
        idle();

        // Random lines
        for (int ln = 0; ln < 40; ln++) begin
            int len;
            len = $urandom_range(8, 60);
            rand_step(1'b0, 1'b1);
            for (int i = 1; i < len - 1; i++) rand_step(1'b1, 1'b0);
            rand_step(1'b0, 1'b0);
        end

        // Fill a line, then reset in the middle of its 600-pixel scanout
        step(1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 1'b1);
        for (int x = 0; x < 600; x++)
            step(1'b1, 10'(x), 10'($urandom) | 10'h001, 1'b0, 10'd0, 1'b0);
        idle();
        step(1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 1'b1);
        for (int x = 0; x < 300; x++) step(1'b0, 10'd0, 10'd0, 1'b1, 10'(x), 1'b0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("pixel_valid_async_reset", 32'(bus.pixel_valid), 32'd0);
        check_eq("ready_async_reset", 32'(ready), 32'd0);
        do_reset();
        run_init();
        read_all();
        read_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vdp_sprite_line_buffer.md
Name: vdp_sprite_line_buffer

Overview:
Double-buffered sprite line buffer that sits between the sprite renderer and the scanout compositor. The renderer writes the back bank for line N+1 while scanout reads the front bank for line N. Every entry is cleared to zero after scanout reads it, so the renderer always starts a line on a blank bank. Banks swap on each line_start. After reset, an init sweep clears both banks.

Parameters:
LINE_WIDTH, 848, number of addressable pixels per line; renderer writes at or above this address are discarded.
ADDR_BITS, 10, address width of each bank; depth = 2^ADDR_BITS.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
line_start  input  1  one-cycle pulse at the start of each scanline; swaps banks
ready  output  1  high once the init sweep has completed
render_write_en  input  1  renderer write strobe (targets the back bank)
render_write_address  input  10  renderer write x position
render_write_data  input  10  {priority[1:0], palette[3:0], pixel[3:0]}
raster_x  input  10  scanout read address
raster_x_valid  input  1  scanout read request for raster_x (front bank)
pixel_valid  output  1  pixel_data corresponds to the request made 2 cycles earlier
pixel_data  output  10  {priority, palette, pixel} read from the front bank
pixel_opaque  output  1  pixel_data[3:0] != 0, qualified by pixel_valid

Behaviour:
- Storage: two banks, each 2^ADDR_BITS x 10 bits, each with one read port and one write port (maps to SB_RAM40 pairs).
- Reset (async, reset_n low) sets these values:
  - state = INIT, init counter = 0, front bank select = 0
  - ready = 0, pixel_valid = 0, pixel_data = 0, pixel_opaque = 0
  - all pipeline valid flags = 0
- Reset asserted mid-operation aborts all activity; the block restarts the INIT sweep on release.
- States:
  - INIT: both write ports write 0 at the init counter; the counter increments each cycle. After address 2^ADDR_BITS-1 is written (1024 cycles), go to RUN and set ready=1. In INIT, render writes, raster reads and line_start are ignored; pixel_valid stays 0.
  - RUN: normal operation; leaves only on reset.
- Bank swap:
  - line_start in RUN toggles front select, registered. The new select applies from the cycle after line_start.
  - A render write or raster read in the same cycle as line_start uses the pre-swap banks.
- Render writes:
  - When render_write_en=1 and render_write_address < LINE_WIDTH, write render_write_data to the back bank at that address.
  - Otherwise the write is dropped; no address wrap or aliasing.
  - The last write to an address wins; the block does no priority resolution.
- Scanout pipeline, for a request at cycle n:
  - Stage 0 (n): latch raster_x, the current front-bank tag and valid.
  - Stage 1 (n+1): RAM data is available. Issue a clear (write 0) to the tagged bank at the latched address.
  - Stage 2 (n+2): pixel_data and pixel_valid are registered. pixel_valid=1 exactly when a request was made at n in RUN.
  - Fixed latency is 2 cycles; throughput is one pixel per cycle.
- Read-after-clear forwarding: if the request at n+1 has the same address and bank tag as the request at n, stage 2 for the second request outputs 0. Each entry is consumed once per line.
- Write-port arbitration:
  - Clear writes go to the front bank's write port; render writes go to the back bank's port.
  - After a swap, a stage-1 clear tagged with the old front bank targets the new back bank. If a render write hits that bank in the same cycle, the render write wins and the clear is dropped.
  - Scanout must hold raster_x_valid low in the cycle of line_start and the cycle before it. This is a system rule; the block does not detect violations.
- Entries that scanout never reads stay dirty. The compositor must read every x in [0, LINE_WIDTH) once per line.
- pixel_opaque is combinationally derived from the registered pixel_data and is gated by pixel_valid.

Test Plan:
- Init sweep: release reset_n -> ready rises exactly 1024 cycles later. Reads issued during INIT give pixel_valid=0. After INIT, every address of both banks reads 0.
- Write/swap/read: write 0x3A5 at x=100 to the back bank, pulse line_start, then read x=100 -> pixel_data=0x3A5 and pixel_opaque=1, 2 cycles after the request. Read x=101 -> 0, opaque=0.
- Clear-on-read: after the above, two more swaps, then read x=100 -> 0. The write at x=100 is also read back as 0 on a back-to-back repeat read of x=100 (forwarding).
- Bounds: render write to x=848 and x=1023 is dropped. After a swap, x=0 still reads 0; there is no wrap.
- Concurrency: a render write to back x=5 in the same cycle as a front read of x=5 returns old front data. The next line shows the written value.
- Async reset mid-line: assert reset_n during a 600-pixel scanout -> pixel_valid drops immediately and ready=0. The INIT sweep reruns, and all entries read 0 afterward.
